// File: rtl/combat_arbiter_pkg.sv
// rtl/combat_arbiter_pkg.sv - shared types, widths and screen constants for the combat arbiter
package combat_pkg;

  typedef enum logic [1:0] {IDLE, STRIKE, KNOCK, KO_ST} arb_state_t;
  typedef enum logic [1:0] {WIN_NONE = 2'd0, WIN_P1 = 2'd1, WIN_P2 = 2'd2} winner_t;

  localparam int X_W   = 10;
  localparam int GAP_W = 12;
  localparam int HP_W  = 4;

  // Screen bounds shared with the per-player knockback controllers
  localparam int SCREEN_MIN_X = 0;
  localparam int SCREEN_MAX_X = 639;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/combat_arbiter_if.sv
// rtl/combat_arbiter_if.sv - player inputs and referee outputs of the combat arbiter
interface combat_arbiter_if;

  logic                         P1_Punch;
  logic                         P2_Punch;
  logic [combat_pkg::X_W-1:0]   P1_Xpos;
  logic [combat_pkg::X_W-1:0]   P2_Xpos;
  logic                         Knock_P1;
  logic                         Knock_P2;
  logic [combat_pkg::HP_W-1:0]  P1_Health;
  logic [combat_pkg::HP_W-1:0]  P2_Health;
  logic                         Busy;
  logic                         KO;
  logic [1:0]                   Winner;

  modport master (
    output P1_Punch, P2_Punch, P1_Xpos, P2_Xpos,
    input  Knock_P1, Knock_P2, P1_Health, P2_Health, Busy, KO, Winner
  );

  modport slave (
    input  P1_Punch, P2_Punch, P1_Xpos, P2_Xpos,
    output Knock_P1, Knock_P2, P1_Health, P2_Health, Busy, KO, Winner
  );

endinterface

// File: rtl/combat_arbiter_punch_gate.sv
// rtl/combat_arbiter_punch_gate.sv - punch press detector with per-player cooldown lockout
module punch_gate #(
  parameter int COOLDOWN = 12
) (
  input  logic clk,
  input  logic Reset,
  input  logic Punch,
  input  logic load,
  input  logic freeze,
  output logic valid
);

  localparam int CW = $clog2(COOLDOWN + 2);

  logic          prev;
  logic [CW-1:0] cooldown;

  // prev resets high so a button held through reset does not count as a press
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prev     <= 1'b1;
      cooldown <= '0;
    end else begin
      prev <= Punch;
      if (load)
        cooldown <= CW'(COOLDOWN);
      else if (!freeze && cooldown != '0)
        cooldown <= cooldown - 1'b1;
    end
  end

  assign valid = Punch & ~prev & (cooldown == '0);

endmodule

// File: rtl/combat_arbiter.sv
// rtl/combat_arbiter.sv - referee granting one hit per exchange, driving knock pulses, health and KO
module combat_arbiter
  import combat_pkg::*;
#(
  parameter int SPRITE_W     = 125,
  parameter int REACH        = 20,
  parameter int KNOCK_FRAMES = 7,
  parameter int COOLDOWN     = 12,
  parameter int HP_INIT      = 10,
  parameter int DAMAGE       = 1
) (
  input logic              clk,
  input logic              Reset,
  combat_arbiter_if.slave  bus
);

  localparam int KW = $clog2(KNOCK_FRAMES + 1);
  localparam logic signed [GAP_W-1:0] SPRITE_S = GAP_W'(SPRITE_W);
  localparam logic signed [GAP_W-1:0] REACH_S  = GAP_W'(REACH);

  arb_state_t        state;
  winner_t           winner;
  logic [KW-1:0]     knock_cnt;
  logic              prio_p2;
  logic              att_p2;
  logic              knock_p1;
  logic              knock_p2;
  logic              busy;
  logic              ko;
  logic [HP_W-1:0]   hp1;
  logic [HP_W-1:0]   hp2;

  logic              valid1;
  logic              valid2;
  logic              idle;
  logic              frozen;
  logic              in_range;
  logic              go1;
  logic              go2;
  logic              pick_p2;
  logic signed [GAP_W-1:0] x1;
  logic signed [GAP_W-1:0] x2;
  logic signed [GAP_W-1:0] gap;

  assign idle   = (state == IDLE);
  assign frozen = (state == KO_ST);

  punch_gate #(.COOLDOWN(COOLDOWN)) u_gate_p1 (
    .clk(clk), .Reset(Reset), .Punch(bus.P1_Punch),
    .load(idle & valid1), .freeze(frozen), .valid(valid1)
  );

  punch_gate #(.COOLDOWN(COOLDOWN)) u_gate_p2 (
    .clk(clk), .Reset(Reset), .Punch(bus.P2_Punch),
    .load(idle & valid2), .freeze(frozen), .valid(valid2)
  );

  // Overlapping sprites give a negative gap, which is always in reach
  assign x1       = {{(GAP_W-X_W){1'b0}}, bus.P1_Xpos};
  assign x2       = {{(GAP_W-X_W){1'b0}}, bus.P2_Xpos};
  assign gap      = x2 - x1 - SPRITE_S;
  assign in_range = (gap <= REACH_S);

  assign go1     = valid1 & in_range;
  assign go2     = valid2 & in_range;
  assign pick_p2 = go2 & (~go1 | prio_p2);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      winner    <= WIN_NONE;
      knock_cnt <= '0;
      prio_p2   <= 1'b0;
      att_p2    <= 1'b0;
      knock_p1  <= 1'b0;
      knock_p2  <= 1'b0;
      busy      <= 1'b0;
      ko        <= 1'b0;
      hp1       <= HP_W'(HP_INIT);
      hp2       <= HP_W'(HP_INIT);
    end else begin
      knock_p1 <= 1'b0;
      knock_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (go1 | go2) begin
            state  <= STRIKE;
            busy   <= 1'b1;
            att_p2 <= pick_p2;
            if (pick_p2) begin
              knock_p1 <= 1'b1;
              hp1      <= sat_sub(hp1, HP_W'(DAMAGE));
            end else begin
              knock_p2 <= 1'b1;
              hp2      <= sat_sub(hp2, HP_W'(DAMAGE));
            end
            if (go1 & go2)
              prio_p2 <= ~prio_p2;
          end
        end
        STRIKE: begin
          // Victim health was already reduced on entry to STRIKE
          if ((att_p2 ? hp1 : hp2) == '0) begin
            state  <= KO_ST;
            busy   <= 1'b0;
            ko     <= 1'b1;
            winner <= att_p2 ? WIN_P2 : WIN_P1;
          end else begin
            state     <= KNOCK;
            knock_cnt <= KW'(KNOCK_FRAMES - 1);
          end
        end
        KNOCK: begin
          if (knock_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            knock_cnt <= knock_cnt - 1'b1;
          end
        end
        KO_ST: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Knock_P1  = knock_p1;
  assign bus.Knock_P2  = knock_p2;
  assign bus.P1_Health = hp1;
  assign bus.P2_Health = hp2;
  assign bus.Busy      = busy;
  assign bus.KO        = ko;
  assign bus.Winner    = winner;

endmodule

// File: tb/tb_combat_arbiter.sv
// tb/tb_combat_arbiter.sv - self-checking bench for combat_arbiter against a timestamp-based referee model
module tb_combat_arbiter;

  localparam int SW    = 125;
  localparam int REACH = 20;
  localparam int KF    = 7;
  localparam int COOL  = 12;
  localparam int HPI   = 10;
  localparam int DMG   = 1;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  combat_arbiter_if bus();

  combat_arbiter #(
    .SPRITE_W(SW), .REACH(REACH), .KNOCK_FRAMES(KF),
    .COOLDOWN(COOL), .HP_INIT(HPI), .DAMAGE(DMG)
  ) dut (
    .clk(clk), .Reset(Reset), .bus(bus)
  );

  // Referee model: edge index t, times at which each player / the referee become free again
  int t, free_t, cd1_t, cd2_t, s_t, ko_t, prio, hp1, hp2, win, hist1, hist2;
  bit exp_k1, exp_k2, exp_busy, exp_ko;
  int exp_win;

  task automatic model_reset();
    t = 0; free_t = 0; cd1_t = 0; cd2_t = 0; s_t = -100; ko_t = BIG;
    prio = 1; hp1 = HPI; hp2 = HPI; win = 0; hist1 = 1; hist2 = 1;
    exp_k1 = 0; exp_k2 = 0; exp_busy = 0; exp_ko = 0; exp_win = 0;
  endtask

  task automatic step();
    bit p1, p2, v1, v2;
    int gap, att;
    p1 = bus.P1_Punch && !hist1;
    p2 = bus.P2_Punch && !hist2;
    hist1 = bus.P1_Punch;
    hist2 = bus.P2_Punch;
    gap = int'(bus.P2_Xpos) - int'(bus.P1_Xpos) - SW;
    @(posedge clk);
    t++;
    exp_k1 = 0;
    exp_k2 = 0;
    if (t >= free_t) begin
      v1 = p1 && (t >= cd1_t);
      v2 = p2 && (t >= cd2_t);
      if (v1) cd1_t = t + COOL + 1;
      if (v2) cd2_t = t + COOL + 1;
      if ((v1 || v2) && gap <= REACH) begin
        if (v1 && v2) begin
          att  = prio;
          prio = 3 - prio;
        end else begin
          att = v1 ? 1 : 2;
        end
        s_t    = t;
        free_t = t + KF + 2;
        if (att == 1) begin
          exp_k2 = 1;
          hp2 = (hp2 > DMG) ? hp2 - DMG : 0;
          if (hp2 == 0) begin ko_t = t + 1; win = 1; free_t = BIG; end
        end else begin
          exp_k1 = 1;
          hp1 = (hp1 > DMG) ? hp1 - DMG : 0;
          if (hp1 == 0) begin ko_t = t + 1; win = 2; free_t = BIG; end
        end
      end
    end
    exp_busy = (t == s_t) || (t > s_t && t <= s_t + KF && t < ko_t);
    exp_ko   = (t >= ko_t);
    exp_win  = exp_ko ? win : 0;
    #1;
  endtask

  task automatic set_pos(input int a, input int b);
    bus.P1_Xpos = 10'(a);
    bus.P2_Xpos = 10'(b);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    bus.P1_Punch = 1'b0;
    bus.P2_Punch = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    Reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && (t + 1 < free_t || t + 1 < cd1_t || t + 1 < cd2_t); i++)
      step();
  endtask

  task automatic test_reset();
    set_pos(100, 240);
    Reset = 1'b1;
    bus.P1_Punch = 1'b0;
    bus.P2_Punch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.Knock_P1 !== 1'b0 || bus.Knock_P2 !== 1'b0) begin bad++; $display("FAIL reset_knock got %0b%0b want 00", bus.Knock_P1, bus.Knock_P2); end
    total++; if (bus.P1_Health !== 4'(HPI) || bus.P2_Health !== 4'(HPI)) begin bad++; $display("FAIL reset_health got %0d/%0d want %0d", bus.P1_Health, bus.P2_Health, HPI); end
    total++; if (bus.Busy !== 1'b0 || bus.KO !== 1'b0 || bus.Winner !== 2'b00) begin bad++; $display("FAIL reset_flags got busy=%0b ko=%0b win=%0d want 0/0/0", bus.Busy, bus.KO, bus.Winner); end
    apply_reset();
  endtask

  task automatic test_hit();
    int busy_n;
    set_pos(100, 240);
    bus.P1_Punch = 1'b1; step(); bus.P1_Punch = 1'b0;
    total++; if (bus.Knock_P2 !== 1'b1 || bus.Knock_P1 !== 1'b0) begin bad++; $display("FAIL hit_knock got p1=%0b p2=%0b want p1=0 p2=1", bus.Knock_P1, bus.Knock_P2); end
    total++; if (bus.P2_Health !== 4'(HPI - DMG)) begin bad++; $display("FAIL hit_health got %0d want %0d", bus.P2_Health, HPI - DMG); end
    busy_n = (bus.Busy === 1'b1) ? 1 : 0;
    step();
    total++; if (bus.Knock_P2 !== 1'b0) begin bad++; $display("FAIL hit_pulse_width got %0b want 0", bus.Knock_P2); end
    for (int i = 0; i < 20 && bus.Busy === 1'b1; i++) begin busy_n++; step(); end
    total++; if (busy_n != 1 + KF) begin bad++; $display("FAIL hit_busy_len got %0d want %0d", busy_n, 1 + KF); end
  endtask

  task automatic test_miss();
    int t0;
    wait_ready();
    set_pos(100, 300);
    bus.P1_Punch = 1'b1; step(); t0 = t; bus.P1_Punch = 1'b0;
    total++; if (bus.Knock_P2 !== 1'b0 || bus.Busy !== 1'b0 || bus.P2_Health !== 4'(HPI - DMG)) begin bad++; $display("FAIL miss_out got k2=%0b busy=%0b hp2=%0d want 0/0/%0d", bus.Knock_P2, bus.Busy, bus.P2_Health, HPI - DMG); end
    while (t < t0 + 10) step();
    set_pos(100, 240);
    bus.P1_Punch = 1'b1; step(); bus.P1_Punch = 1'b0;
    total++; if (bus.Knock_P2 !== 1'b0) begin bad++; $display("FAIL miss_cooldown_block got %0b want 0", bus.Knock_P2); end
    step();
    bus.P1_Punch = 1'b1; step(); bus.P1_Punch = 1'b0;
    total++; if (bus.Knock_P2 !== 1'b1 || bus.P2_Health !== 4'(HPI - 2 * DMG)) begin bad++; $display("FAIL miss_cooldown_expire got k2=%0b hp2=%0d want 1/%0d", bus.Knock_P2, bus.P2_Health, HPI - 2 * DMG); end
  endtask

  task automatic test_tie();
    wait_ready();
    bus.P1_Punch = 1'b1; bus.P2_Punch = 1'b1; step();
    bus.P1_Punch = 1'b0; bus.P2_Punch = 1'b0;
    total++; if (bus.Knock_P2 !== 1'b1 || bus.Knock_P1 !== 1'b0) begin bad++; $display("FAIL tie_first got p1=%0b p2=%0b want p1=0 p2=1", bus.Knock_P1, bus.Knock_P2); end
    wait_ready();
    bus.P1_Punch = 1'b1; bus.P2_Punch = 1'b1; step();
    bus.P1_Punch = 1'b0; bus.P2_Punch = 1'b0;
    total++; if (bus.Knock_P1 !== 1'b1 || bus.Knock_P2 !== 1'b0) begin bad++; $display("FAIL tie_second got p1=%0b p2=%0b want p1=1 p2=0", bus.Knock_P1, bus.Knock_P2); end
  endtask

  task automatic test_press_during_knock();
    wait_ready();
    bus.P1_Punch = 1'b1; step(); bus.P1_Punch = 1'b0;
    step(); step();
    bus.P2_Punch = 1'b1; step(); bus.P2_Punch = 1'b0;
    total++; if (bus.Knock_P1 !== 1'b0 || bus.Busy !== 1'b1) begin bad++; $display("FAIL knock_ignore got k1=%0b busy=%0b want 0/1", bus.Knock_P1, bus.Busy); end
    for (int i = 0; i < 20 && t + 1 < free_t; i++) step();
    bus.P2_Punch = 1'b1; step(); bus.P2_Punch = 1'b0;
    total++; if (bus.Knock_P1 !== 1'b1) begin bad++; $display("FAIL knock_then_idle_press got %0b want 1", bus.Knock_P1); end
  endtask

  task automatic test_ko();
    apply_reset();
    set_pos(200, 330);
    for (int n = 0; n < HPI; n++) begin
      for (int i = 0; i < 100 && (t + 1 < free_t || t + 1 < cd1_t); i++) step();
      bus.P1_Punch = 1'b1; step(); bus.P1_Punch = 1'b0;
      total++; if (bus.Knock_P2 !== 1'b1 || bus.P2_Health !== 4'(HPI - n - 1)) begin bad++; $display("FAIL ko_hit%0d got k2=%0b hp2=%0d want 1/%0d", n, bus.Knock_P2, bus.P2_Health, HPI - n - 1); end
    end
    step();
    total++; if (bus.KO !== 1'b1 || bus.Winner !== 2'b01 || bus.Busy !== 1'b0) begin bad++; $display("FAIL ko_state got ko=%0b win=%0d busy=%0b want 1/1/0", bus.KO, bus.Winner, bus.Busy); end
    for (int n = 0; n < 3; n++) begin
      repeat (14) step();
      bus.P1_Punch = 1'b1; bus.P2_Punch = 1'b1; step();
      bus.P1_Punch = 1'b0; bus.P2_Punch = 1'b0;
      total++; if (bus.Knock_P1 !== 1'b0 || bus.Knock_P2 !== 1'b0 || bus.KO !== 1'b1) begin bad++; $display("FAIL ko_terminal got k=%0b%0b ko=%0b want 00/1", bus.Knock_P1, bus.Knock_P2, bus.KO); end
    end
  endtask

  task automatic test_reset_mid_knock();
    apply_reset();
    set_pos(100, 240);
    bus.P1_Punch = 1'b1; step(); bus.P1_Punch = 1'b0;
    step(); step(); step();
    #2;
    Reset = 1'b1;
    #1;
    total++; if (bus.Busy !== 1'b0 || bus.Knock_P2 !== 1'b0 || bus.P2_Health !== 4'(HPI) || bus.KO !== 1'b0 || bus.Winner !== 2'b00) begin bad++; $display("FAIL async_reset got busy=%0b k2=%0b hp2=%0d ko=%0b win=%0d want 0/0/%0d/0/0", bus.Busy, bus.Knock_P2, bus.P2_Health, bus.KO, bus.Winner, HPI); end
    bus.P1_Punch = 1'b1;
    @(posedge clk);
    #2;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.Knock_P2 !== 1'b0 || bus.Busy !== 1'b0 || bus.P2_Health !== 4'(HPI)) begin bad++; $display("FAIL held_through_reset got k2=%0b busy=%0b hp2=%0d want 0/0/%0d", bus.Knock_P2, bus.Busy, bus.P2_Health, HPI); end
    end
    bus.P1_Punch = 1'b0;
  endtask

  task automatic test_random();
    int a;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) apply_reset();
      if ($urandom_range(0, 15) == 0) begin
        a = $urandom_range(0, 700);
        set_pos(a, a + SW + $urandom_range(0, 60) - 30);
      end
      bus.P1_Punch = ($urandom_range(0, 2) == 0);
      bus.P2_Punch = ($urandom_range(0, 2) == 0);
      step();
      total++; if (bus.Knock_P1 !== exp_k1) begin bad++; $display("FAIL rnd_knock_p1 t=%0d got %0b want %0b", t, bus.Knock_P1, exp_k1); end
      total++; if (bus.Knock_P2 !== exp_k2) begin bad++; $display("FAIL rnd_knock_p2 t=%0d got %0b want %0b", t, bus.Knock_P2, exp_k2); end
      total++; if (bus.P1_Health !== 4'(hp1)) begin bad++; $display("FAIL rnd_hp1 t=%0d got %0d want %0d", t, bus.P1_Health, hp1); end
      total++; if (bus.P2_Health !== 4'(hp2)) begin bad++; $display("FAIL rnd_hp2 t=%0d got %0d want %0d", t, bus.P2_Health, hp2); end
      total++; if (bus.Busy !== exp_busy) begin bad++; $display("FAIL rnd_busy t=%0d got %0b want %0b", t, bus.Busy, exp_busy); end
      total++; if (bus.KO !== exp_ko || bus.Winner !== 2'(exp_win)) begin bad++; $display("FAIL rnd_ko t=%0d got ko=%0b win=%0d want %0b/%0d", t, bus.KO, bus.Winner, exp_ko, exp_win); end
      total++; if (bus.Knock_P1 === 1'b1 && bus.Knock_P2 === 1'b1) begin bad++; $display("FAIL rnd_exclusive t=%0d got both knocks want at most one", t); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.P1_Punch = 1'b0;
    bus.P2_Punch = 1'b0;
    set_pos(100, 240);
    model_reset();
    test_reset();
    test_hit();
    test_miss();
    test_tie();
    test_press_during_knock();
    test_ko();
    test_reset_mid_knock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
